// File: rtl/m_store_queue.sv
// MEM-stage store queue: aligns stores onto a DATA_W-bit bus, buffers them in a DEPTH-entry FIFO
// and drains them as valid/ready beats. Define M_STORE_SPLIT_EN to split misaligned stores into two beats.
module m_store_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [3:0]            st_op,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic                  flush,
    output logic                  st_adel,
    output logic                  m_data_valid,
    input  logic                  m_data_ready,
    output logic [ADDR_W-1:0]     m_data_addr,
    output logic [DATA_W/8-1:0]   m_data_byteen,
    output logic [DATA_W-1:0]     m_data_wdata,
    output logic                  sq_empty
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    logic [3:0]          size_bytes;
    logic [3:0]          size_m1;
    logic                op_legal;
    logic                misaligned;
    logic [LB-1:0]       sh;
    logic [2*NB-1:0]     size_mask;
    logic [2*NB-1:0]     mask_al;
    logic [2*DATA_W-1:0] data_sh;
    logic [2*DATA_W-1:0] data_al;
    logic [ADDR_W-1:0]   base_addr;
    logic                split_w;
    logic                push;
    logic                pop;

    always_comb begin
        size_bytes = 4'd1;
        op_legal   = 1'b0;
        case (st_op)
            4'b1000: begin size_bytes = 4'd1; op_legal = 1'b1; end
            4'b0111: begin size_bytes = 4'd2; op_legal = 1'b1; end
            4'b0110: begin size_bytes = 4'd4; op_legal = 1'b1; end
            4'b1010: begin size_bytes = 4'd8; op_legal = (DATA_W == 64); end
            default: begin size_bytes = 4'd1; op_legal = 1'b0; end
        endcase
    end

    assign size_m1    = size_bytes - 4'd1;
    assign misaligned = |(st_addr[3:0] & size_m1);
    assign sh         = st_addr[LB-1:0];
    assign base_addr  = {st_addr[ADDR_W-1:LB], {LB{1'b0}}};
    assign mask_al    = size_mask << sh;
    assign data_sh    = {{DATA_W{1'b0}}, st_data} << {sh, 3'b000};

    // Lanes outside the store size are zeroed so upper garbage in st_data never reaches the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 2*NB; gi++) begin : g_lane
            assign size_mask[gi]          = (gi < int'(size_bytes));
            assign data_al[8*gi +: 8]     = mask_al[gi] ? data_sh[8*gi +: 8] : 8'h00;
        end
    endgenerate

`ifdef M_STORE_SPLIT_EN
    assign split_w = |mask_al[2*NB-1:NB];
    assign st_adel = 1'b0;
`else
    assign split_w = 1'b0;
    assign st_adel = st_valid & op_legal & misaligned;
`endif

    // FIFO storage and control
    logic [ADDR_W-1:0]   fifo_addr_q  [DEPTH];
    logic [2*NB-1:0]     fifo_mask_q  [DEPTH];
    logic [2*DATA_W-1:0] fifo_data_q  [DEPTH];
    logic                fifo_split_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rd_nxt;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     byteen_q, byteen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              beat_done;

    assign st_ready = (count_q != CW'(DEPTH));
    assign push     = st_valid & st_ready & ~flush & op_legal & ~st_adel;
    assign rd_nxt   = rd_ptr_q + PW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= base_addr;
            fifo_mask_q[wr_ptr_q]  <= mask_al;
            fifo_data_q[wr_ptr_q]  <= data_al;
            fifo_split_q[wr_ptr_q] <= split_w;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        byteen_d  = byteen_q;
        wdata_d   = wdata_q;
        beat_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d  = S_BEAT0;
                    valid_d  = 1'b1;
                    addr_d   = fifo_addr_q[rd_ptr_q];
                    byteen_d = fifo_mask_q[rd_ptr_q][NB-1:0];
                    wdata_d  = fifo_data_q[rd_ptr_q][DATA_W-1:0];
                end
            end
            S_BEAT0: begin
                if (m_data_ready) begin
                    if (fifo_split_q[rd_ptr_q]) begin
                        state_d  = S_BEAT1;
                        addr_d   = fifo_addr_q[rd_ptr_q] + ADDR_W'(NB);
                        byteen_d = fifo_mask_q[rd_ptr_q][2*NB-1:NB];
                        wdata_d  = fifo_data_q[rd_ptr_q][2*DATA_W-1:DATA_W];
                    end else begin
                        beat_done = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (m_data_ready) beat_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // An entry enqueued this same cycle is not yet readable, so it waits for IDLE to pick it up.
        if (beat_done) begin
            if (count_q >= CW'(2)) begin
                state_d  = S_BEAT0;
                valid_d  = 1'b1;
                addr_d   = fifo_addr_q[rd_nxt];
                byteen_d = fifo_mask_q[rd_nxt][NB-1:0];
                wdata_d  = fifo_data_q[rd_nxt][DATA_W-1:0];
            end else begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                addr_d   = '0;
                byteen_d = '0;
                wdata_d  = '0;
            end
        end
    end

    assign pop      = beat_done;
    assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign m_data_valid  = valid_q;
    assign m_data_addr   = addr_q;
    assign m_data_byteen = byteen_q;
    assign m_data_wdata  = wdata_q;
    assign sq_empty      = (count_q == '0) & ~valid_q;

endmodule

// File: tb/tb_m_store_queue.sv
// Directed bench for m_store_queue: a 32-bit instance for alignment, full, flush and drop cases,
// and a 64-bit instance for dword stores and asynchronous reset.
module tb_m_store_queue;
    localparam logic [3:0] OP_SB = 4'b1000;
    localparam logic [3:0] OP_SH = 4'b0111;
    localparam logic [3:0] OP_SW = 4'b0110;
    localparam logic [3:0] OP_SD = 4'b1010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        st_valid = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic [3:0]  st_op = 4'b0;
    logic [31:0] st_addr = '0, st_data = '0;
    logic        st_ready, st_adel, m_valid, sq_empty;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_byteen;

    logic        st_valid64 = 1'b0, flush64 = 1'b0, m_ready64 = 1'b0;
    logic [3:0]  st_op64 = 4'b0;
    logic [31:0] st_addr64 = '0;
    logic [63:0] st_data64 = '0;
    logic        st_ready64, st_adel64, m_valid64, sq_empty64;
    logic [31:0] m_addr64;
    logic [63:0] m_wdata64;
    logic [7:0]  m_byteen64;

    int n_pass = 0;
    int n_total = 0;
    int nbeats;
    logic [31:0] beat_addr [2];

    always #5 clk = ~clk;

    m_store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .flush(flush), .st_adel(st_adel),
        .m_data_valid(m_valid), .m_data_ready(m_ready), .m_data_addr(m_addr),
        .m_data_byteen(m_byteen), .m_data_wdata(m_wdata), .sq_empty(sq_empty)
    );

    m_store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset(reset), .st_valid(st_valid64), .st_ready(st_ready64), .st_op(st_op64),
        .st_addr(st_addr64), .st_data(st_data64), .flush(flush64), .st_adel(st_adel64),
        .m_data_valid(m_valid64), .m_data_ready(m_ready64), .m_data_addr(m_addr64),
        .m_data_byteen(m_byteen64), .m_data_wdata(m_wdata64), .sq_empty(sq_empty64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic f);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
        flush    = f;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();

        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_valid",    64'(m_valid),  64'd0);
        check("rst_addr",     64'(m_addr),   64'd0);
        check("rst_byteen",   64'(m_byteen), 64'd0);
        check("rst_wdata",    64'(m_wdata),  64'd0);
        check("rst_sq_empty", 64'(sq_empty), 64'd1);

        // sb 0x1003; upper data bits must not leak onto the bus
        m_ready = 1'b1;
        drive(1'b1, OP_SB, 32'h1003, 32'h1234_56AB, 1'b0);
        #1 check("sb_adel", 64'(st_adel), 64'd0);
        tick();
        drive(1'b0, OP_SB, 32'h0, 32'h0, 1'b0);
        check("sb_t1_valid", 64'(m_valid), 64'd0);
        check("sb_t1_sq_empty", 64'(sq_empty), 64'd0);
        tick();
        check("sb_valid",  64'(m_valid),  64'd1);
        check("sb_addr",   64'(m_addr),   64'h1000);
        check("sb_byteen", 64'(m_byteen), 64'h8);
        check("sb_wdata",  64'(m_wdata),  64'hAB00_0000);
        tick();
        check("sb_done_valid", 64'(m_valid), 64'd0);
        check("sb_done_empty", 64'(sq_empty), 64'd1);

`ifdef M_STORE_SPLIT_EN
        drive(1'b1, OP_SW, 32'h2001, 32'h1122_3344, 1'b0);
        #1 check("split_adel", 64'(st_adel), 64'd0);
        tick();
        drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0);
        tick();
        check("split_b0_valid",  64'(m_valid),  64'd1);
        check("split_b0_addr",   64'(m_addr),   64'h2000);
        check("split_b0_byteen", 64'(m_byteen), 64'hE);
        check("split_b0_wdata",  64'(m_wdata),  64'h2233_4400);
        tick();
        check("split_b1_valid",  64'(m_valid),  64'd1);
        check("split_b1_addr",   64'(m_addr),   64'h2004);
        check("split_b1_byteen", 64'(m_byteen), 64'h1);
        check("split_b1_wdata",  64'(m_wdata),  64'h0000_0011);
        tick();
        check("split_done_valid", 64'(m_valid), 64'd0);
        check("split_done_empty", 64'(sq_empty), 64'd1);
`else
        // misaligned sh: exception regardless of flush, nothing queued
        drive(1'b1, OP_SH, 32'h3001, 32'h5555, 1'b1);
        #1 check("adel_flush", 64'(st_adel), 64'd1);
        flush = 1'b0;
        #1 check("adel_sh", 64'(st_adel), 64'd1);
        tick();
        drive(1'b0, OP_SH, 32'h3001, 32'h0, 1'b0);
        #1 check("adel_novalid", 64'(st_adel), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("adel_no_beat", 64'(m_valid), 64'd0);
            check("adel_empty", 64'(sq_empty), 64'd1);
            tick();
        end
`endif

        // dword is illegal on a 32-bit bus: silently dropped
        drive(1'b1, OP_SD, 32'h6000, 32'hFFFF_FFFF, 1'b0);
        #1 check("sd32_adel", 64'(st_adel), 64'd0);
        tick();
        drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("sd32_no_beat", 64'(m_valid), 64'd0);
            check("sd32_empty", 64'(sq_empty), 64'd1);
            tick();
        end

        // fill to full with the bus stalled
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_SW, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
            #1 check("full_st_ready", 64'(st_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0);
        check("full_hold_ready", 64'(st_ready), 64'd0);
        check("full_b0_valid",   64'(m_valid),  64'd1);
        check("full_b0_addr",    64'(m_addr),   64'h100);
        check("full_b0_wdata",   64'(m_wdata),  64'hA0);
        m_ready = 1'b1;
        #1 check("full_pop_no_bypass", 64'(st_ready), 64'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            check("drain_st_ready", 64'(st_ready), 64'd1);
            check("drain_valid",    64'(m_valid),  64'd1);
            check("drain_addr",     64'(m_addr),   64'h100 + 64'(4*i));
            check("drain_wdata",    64'(m_wdata),  64'hA0 + 64'(i));
            tick();
        end
        check("drain_done_valid", 64'(m_valid), 64'd0);
        check("drain_done_empty", 64'(sq_empty), 64'd1);

        // flush drops only the store presented with it
        m_ready = 1'b0;
        drive(1'b1, OP_SW, 32'h200, 32'hB0, 1'b0);
        tick();
        drive(1'b1, OP_SW, 32'h204, 32'hB1, 1'b0);
        tick();
        drive(1'b1, OP_SW, 32'h4000, 32'hB2, 1'b1);
        tick();
        drive(1'b0, OP_SW, 32'h0, 32'h0, 1'b0);
        m_ready = 1'b1;
        nbeats = 0;
        beat_addr[0] = '0;
        beat_addr[1] = '0;
        for (int i = 0; i < 6; i++) begin
            if (m_valid) begin
                if (nbeats < 2) beat_addr[nbeats] = m_addr;
                nbeats = nbeats + 1;
            end
            tick();
        end
        check("flush_nbeats", 64'(nbeats), 64'd2);
        check("flush_beat0",  64'(beat_addr[0]), 64'h200);
        check("flush_beat1",  64'(beat_addr[1]), 64'h204);
        check("flush_empty",  64'(sq_empty), 64'd1);

        // 64-bit bus: dword store, then asynchronous reset while stalled
        st_valid64 = 1'b1;
        st_op64    = OP_SD;
        st_addr64  = 32'h5008;
        st_data64  = 64'h0102_0304_0506_0708;
        #1 check("sd64_adel", 64'(st_adel64), 64'd0);
        tick();
        st_valid64 = 1'b0;
        tick();
        check("sd64_valid",  64'(m_valid64),  64'd1);
        check("sd64_addr",   64'(m_addr64),   64'h5008);
        check("sd64_byteen", 64'(m_byteen64), 64'hFF);
        check("sd64_wdata",  m_wdata64,       64'h0102_0304_0506_0708);
        tick();
        check("sd64_stall_valid", 64'(m_valid64), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_st_ready", 64'(st_ready64),  64'd1);
        check("arst_valid",    64'(m_valid64),   64'd0);
        check("arst_addr",     64'(m_addr64),    64'd0);
        check("arst_byteen",   64'(m_byteen64),  64'd0);
        check("arst_wdata",    m_wdata64,        64'd0);
        check("arst_sq_empty", 64'(sq_empty64),  64'd1);
        #3 reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/m_store_queue.md
# m_store_queue

Parametrised MEM-stage store path: accepts stores from the M stage, aligns data and generates byte enables for a DATA_W-bit data bus, buffers them in a DEPTH-entry FIFO, and drains them to data memory under a valid/ready handshake. It replaces the purely combinational single-word store extender. It adds three things: bus-width generality, write buffering, and optional splitting of misaligned stores into two bus beats.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64. NB = DATA_W/8 byte lanes, LB = log2(NB).
- ADDR_W, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  the M stage presents a store this cycle.
- st_ready  out  1  the queue can accept; equals !full.
- st_op  in  4  store type: 4'b1000 = byte, 4'b0111 = half, 4'b0110 = word, 4'b1010 = dword (legal only when DATA_W = 64).
- st_addr  in  ADDR_W  byte address.
- st_data  in  DATA_W  store data, right-justified.
- flush  in  1  exception or interrupt in M; suppresses acceptance this cycle.
- st_adel  out  1  combinational; misaligned-store exception (see Configuration).
- m_data_valid  out  1  a bus beat is pending.
- m_data_ready  in  1  memory accepts the beat.
- m_data_addr  out  ADDR_W  beat address, with the low LB bits forced to 0.
- m_data_byteen  out  NB  lane enables.
- m_data_wdata  out  DATA_W  lane-aligned data.
- sq_empty  out  1  FIFO empty and no beat pending. Used for sync/eret draining.

## Operation
- Size S: byte 1, half 2, word 4, dword 8. Misaligned means addr mod S != 0.
- Legal op: an op listed above, with dword excluded when DATA_W = 32.
- Accept condition: st_valid & st_ready & !flush & legal op & !st_adel.
- Illegal op: consumed and dropped; no entry is created, no exception is raised.
- Alignment: sh = st_addr[LB-1:0].
  - Mask (2*NB bits) = ((1<<S)-1) << sh.
  - Data (2*DATA_W bits) = data zero-extended, then shifted left by 8*sh.
  - Non-enabled lanes carry 0.
- FIFO entry: aligned base address, 2*NB mask, 2*DATA_W data, and a split flag. The split flag is set when mask[2*NB-1:NB] != 0.
- Drain FSM states:
  - IDLE: FIFO not empty, so load beat 0 from the head. Next state is BEAT0.
  - BEAT0: drive base address, mask low half, data low half.
    - On m_data_ready with split = 1: load beat 1 and go to BEAT1.
    - On m_data_ready with split = 0: pop. If the FIFO is still non-empty, load the next head and stay in BEAT0; otherwise go to IDLE.
  - BEAT1: drive base + NB, mask high half, data high half. On m_data_ready, pop and continue as in BEAT0.
- Beat outputs are registered and held stable while m_data_valid & !m_data_ready.
- Full: st_ready = 0. A pop in the same cycle does not raise st_ready (no bypass).
- Enqueue and pop in the same cycle: both take effect; the count is unchanged.
- Pointers wrap modulo DEPTH. An occupancy counter with DEPTH+1 states distinguishes full from empty.
- flush discards only the store presented in that cycle. Already-queued entries always drain, because they are committed.
- Reset mid-beat: the beat is abandoned and the FIFO is emptied. No partial replay.

## Timing
- Reset values: st_ready 1, m_data_valid 0, m_data_addr 0, m_data_byteen 0, m_data_wdata 0, sq_empty 1, FSM IDLE.
- Latency: a store accepted in cycle t into an empty queue appears on the bus in cycle t+2 (enqueue at t, head load at t+1, valid at t+2).
- Throughput: one unsplit beat per cycle while m_data_ready = 1. A split store uses two consecutive beats.
- st_adel is combinational from st_valid, st_op and st_addr; it is not gated by flush.

## Configuration
- M_STORE_SPLIT_EN defined:
  - Misaligned legal stores are accepted and split as described above.
  - st_adel is tied to 0.
- M_STORE_SPLIT_EN undefined:
  - st_adel = st_valid & legal op & misaligned.
  - A flagged store is not enqueued.
  - The split flag is never set, and the FSM never enters BEAT1.

## Test plan
- DATA_W=32, sb at 0x1003, data 0xAB -> one beat: addr 0x1000, byteen 4'b1000, wdata 0xAB000000. The beat is on the bus 2 cycles after acceptance.
- DATA_W=32, SPLIT_EN defined, sw at 0x2001, data 0x11223344 -> beat 0: addr 0x2000, byteen 4'b1110, wdata 0x22334400. Beat 1: addr 0x2004, byteen 4'b0001, wdata 0x00000011.
- SPLIT_EN undefined, sh at 0x3001 -> st_adel = 1 in the same cycle; no bus beat; sq_empty remains 1.
- DEPTH=4, m_data_ready held 0, five back-to-back sw -> the first four are accepted and st_ready = 0 on the 5th. Then m_data_ready = 1 -> four beats drain in order, and st_ready rises the cycle after the first pop.
- flush asserted together with a valid sw at 0x4000 while 2 entries are queued -> the sw is dropped. Exactly 2 beats are issued, then sq_empty = 1.
- DATA_W=64, sd at 0x5008, data 0x0102030405060708 -> addr 0x5008, byteen 8'hFF, wdata equal to the input data. Assert reset mid-stall -> all outputs return to their reset values asynchronously.
